tx_tick_gen: RTL and testbench

Synthesizable, parametrised successor to the free-running simulation clock source on the tx side. Runs on the system clock and derives a programmable divided clock-enable stream for tx sample pacing:
- a ~50% duty divided clock (clk_div)
- a one-cycle period strobe (tick)
- a mid-period strobe (tick_mid)
- a running tick counter

It sits between the system clock and the tx sample/modulator logic. No gated or generated clocks; all outputs are synchronous to clk.

---
 rtl/tx_tick_pkg.sv | 11 +
 rtl/tx_tick_cnt.sv | 50 +++++
 rtl/tx_tick_gen.sv | 103 ++++++++++
 tb/tb_tx_tick_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_tick_pkg.sv
// Shared defaults and constants for the tx tick generator.
package tx_tick_pkg;

  localparam int unsigned DIV_W_DEF   = 16;
  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned DIV_RST_DEF = 4;

  // Smallest legal divide ratio; a requested ratio of 0 is clamped to this.
  localparam int unsigned DIV_MIN = 1;

endpackage

// File: rtl/tx_tick_cnt.sv
// Loadable wrap counter with registered lookahead decode of the low half,
// terminal and half-point so the strobes line up with the count they describe.
module tx_tick_cnt
  import tx_tick_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             act,
  input  logic [DIV_W-1:0] div,
  output logic             clk_div,
  output logic             tick,
  output logic             tick_mid
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_clamp;
  logic [DIV_W:0]   half_d;
  logic             load;

  always_comb begin
    div_clamp = (div == '0) ? DIV_W'(DIV_MIN) : div;
    // The ratio only changes when the count returns to zero, so no runt periods.
    load      = restart | (cnt_q == div_q - DIV_W'(1));
    cnt_d     = load ? '0 : cnt_q + DIV_W'(1);
    div_d     = load ? div_clamp : div_q;
    half_d    = ({1'b0, div_d} + (DIV_W + 1)'(1)) >> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      div_q    <= DIV_W'(DIV_RST);
      clk_div  <= 1'b0;
      tick     <= 1'b0;
      tick_mid <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      clk_div  <= act & ({1'b0, cnt_d} < half_d);
      tick     <= act & (cnt_d == div_d - DIV_W'(1));
      tick_mid <= act & (div_d > DIV_W'(1)) & ({1'b0, cnt_d} == half_d);
    end
  end

endmodule

// File: rtl/tx_tick_gen.sv
// Programmable tx tick generator: divided clock-enable, period/mid strobes and
// tick counter. Optional burst mode is built in with TX_TICK_GEN_BURST_EN.
module tx_tick_gen
  import tx_tick_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  output logic             clk_div,
  output logic             tick,
  output logic             tick_mid,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             busy
`ifdef TX_TICK_GEN_BURST_EN
  ,
  input  logic [CNT_W-1:0] burst_len,
  output logic             burst_done
`endif
);

  logic busy_d;
  logic done_d;
  logic restart;

`ifdef TX_TICK_GEN_BURST_EN
  logic             en_q;
  logic [CNT_W-1:0] burst_len_q, burst_len_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    burst_len_d = burst_len_q;
    burst_cnt_d = burst_cnt_q;
    done_d      = burst_done;
    if (start | (en & ~en_q)) burst_len_d = burst_len;
    if (start | ~en | ~en_q) begin
      burst_cnt_d = '0;
    end else if (tick) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end
    if (start | ~en) begin
      done_d = 1'b0;
    end else if (tick && (burst_len_q != '0) &&
                 ((burst_cnt_q + CNT_W'(1)) == burst_len_q)) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      burst_len_q <= '0;
      burst_cnt_q <= '0;
      burst_done  <= 1'b0;
    end else begin
      en_q        <= en;
      burst_len_q <= burst_len_d;
      burst_cnt_q <= burst_cnt_d;
      burst_done  <= done_d;
    end
  end
`else
  assign done_d = 1'b0;
`endif

  // A fresh period starts on start, on the first active cycle, and while idle.
  assign busy_d  = en & ~done_d;
  assign restart = start | ~busy_d | ~busy;

  tx_tick_cnt #(
    .DIV_W  (DIV_W),
    .DIV_RST(DIV_RST)
  ) u_period (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .act     (busy_d),
    .div     (div),
    .clk_div (clk_div),
    .tick    (tick),
    .tick_mid(tick_mid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      busy <= busy_d;
      if (start) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_tick_gen.sv
// Directed plus randomized bench for tx_tick_gen against a period-level model.
module tb_tx_tick_gen;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] div = 16'd4;
  logic          clk_div, tick, tick_mid, busy;
  logic [CW-1:0] tick_cnt;
`ifdef TX_TICK_GEN_BURST_EN
  logic [CW-1:0] burst_len = '0;
  logic          burst_done;
`endif

  always #5 clk = ~clk;

  tx_tick_gen #(
    .DIV_W  (DW),
    .CNT_W  (CW),
    .DIV_RST(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .div       (div),
    .clk_div   (clk_div),
    .tick      (tick),
    .tick_mid  (tick_mid),
    .tick_cnt  (tick_cnt),
    .busy      (busy)
`ifdef TX_TICK_GEN_BURST_EN
    ,
    .burst_len (burst_len),
    .burst_done(burst_done)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: position inside the current period, its ratio, completed periods.
  int m_pos, m_ratio, m_tcnt, m_blen, m_bcnt;
  bit m_busy, m_en_prev, m_done;

  function automatic int clamp_div(int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic bit exp_tick();
    return m_busy && (m_pos == m_ratio - 1);
  endfunction

  function automatic bit exp_clk_div();
    return m_busy && (m_pos < (m_ratio + 1) / 2);
  endfunction

  function automatic bit exp_mid();
    return m_busy && (m_ratio > 1) && (m_pos == (m_ratio + 1) / 2);
  endfunction

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check1("clk_div", 32'(clk_div), 32'(exp_clk_div()));
    check1("tick", 32'(tick), 32'(exp_tick()));
    check1("tick_mid", 32'(tick_mid), 32'(exp_mid()));
    check1("tick_cnt", 32'(tick_cnt), 32'(m_tcnt));
    check1("busy", 32'(busy), 32'(m_busy));
`ifdef TX_TICK_GEN_BURST_EN
    check1("burst_done", 32'(burst_done), 32'(m_done));
`endif
  endtask

  task automatic model_reset();
    m_pos = 0; m_ratio = 4; m_tcnt = 0; m_blen = 0; m_bcnt = 0;
    m_busy = 0; m_en_prev = 0; m_done = 0;
  endtask

  task automatic model_edge();
    bit t, done_n, busy_n;
    int bcnt_n;
    t = exp_tick();
    done_n = 0;
    if (start) m_tcnt = 0;
    else if (t) m_tcnt = (m_tcnt + 1) % (1 << CW);
`ifdef TX_TICK_GEN_BURST_EN
    done_n = m_done;
    if (start || !en) done_n = 0;
    else if (m_blen != 0 && t && m_bcnt + 1 == m_blen) done_n = 1;
    if (start || !en || !m_en_prev) bcnt_n = 0;
    else bcnt_n = m_bcnt + int'(t);
    if (start || (en && !m_en_prev)) m_blen = int'(burst_len);
    m_bcnt = bcnt_n;
    m_done = done_n;
`endif
    busy_n = en && !done_n;
    if (!busy_n || start || !m_busy || t) begin
      m_pos = 0;
      m_ratio = clamp_div(int'(div));
    end else begin
      m_pos = m_pos + 1;
    end
    m_busy = busy_n;
    m_en_prev = en;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int n, guard;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // div=4 from reset: 1100 pattern, five periods complete after 21 edges.
    div = 16'd4; en = 1'b1;
    repeat (21) step();
    check1("tick_cnt_div4", 32'(tick_cnt), 32'd5);

    // div=5, then div=2 requested mid-period.
    div = 16'd5;
    repeat (12) step();
    div = 16'd2;
    repeat (10) step();

    // Divide-by-0 and divide-by-1.
    div = 16'd0;
    repeat (6) step();
    div = 16'd1;
    repeat (6) step();

    // en dropped at cnt=2 of div=8.
    div = 16'd8; start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    en = 1'b0;
    step();
    check1("en_drop_busy", 32'(busy), 32'd0);
    step();

    // Asynchronous reset mid-period.
    en = 1'b1; div = 16'd6;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) step();

    // 4-bit tick counter wraps 15 -> 0 -> 1.
    div = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (17) step();
    check1("tick_cnt_wrap", 32'(tick_cnt), 32'd1);

    // start on a wrap cycle clears the count instead of incrementing it.
    div = 16'd3;
    guard = 0;
    step();
    while (!exp_tick() && guard < 10) begin
      step();
      guard++;
    end
    check1("wrap_tick_seen", 32'(tick), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check1("start_wins_cnt", 32'(tick_cnt), 32'd0);
    repeat (4) step();

    // Randomized enable / start / ratio traffic.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) div = 16'($urandom_range(0, 9));
`ifdef TX_TICK_GEN_BURST_EN
      burst_len = CW'($urandom_range(0, 4));
`endif
      step();
    end
    start = 1'b0;

`ifdef TX_TICK_GEN_BURST_EN
    // Burst of three ticks at div=4, then a restart.
    en = 1'b0;
    step();
    burst_len = 4'd3; div = 16'd4; en = 1'b1;
    n = 0;
    repeat (20) begin
      step();
      if (tick) n++;
    end
    check1("burst_ticks", 32'(n), 32'd3);
    check1("burst_done_held", 32'(burst_done), 32'd1);
    check1("burst_busy", 32'(busy), 32'd0);
    check1("burst_clk_div", 32'(clk_div), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    check1("burst_restart_busy", 32'(busy), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
